// File: rtl/psram_bist_pkg.sv
// Shared types and constants for the PSRAM built-in self-test sequencer.
package psram_bist_pkg;

    typedef enum logic [3:0] {
        IDLE,
        WR_REQ,
        WR_ACK,
        WR_WAIT,
        RD_REQ,
        RD_ACK,
        RD_WAIT,
        CHECK,
        DONE
    } state_t;

    // Fibonacci taps for x^16 + x^14 + x^13 + x^11 + 1 (bits 15, 13, 12, 10)
    localparam logic [15:0] LFSR_TAPS           = 16'hB400;
    localparam logic [15:0] DEFAULT_PATTERN_XOR = 16'hA55A;

endpackage

// File: rtl/psram_bist_if.sv
// Request/response bus between the BIST sequencer (master) and the PSRAM controller (slave).
interface psram_bist_if #(
    parameter int unsigned ADDR_W = 24
);
    logic              o_psram_stb;
    logic              o_psram_we;
    logic [ADDR_W-1:0] o_psram_addr;
    logic [15:0]       o_psram_din;
    logic              i_psram_busy;
    logic              i_psram_done;
    logic [15:0]       i_psram_dout;

    modport master (
        output o_psram_stb, o_psram_we, o_psram_addr, o_psram_din,
        input  i_psram_busy, i_psram_done, i_psram_dout
    );

    modport slave (
        input  o_psram_stb, o_psram_we, o_psram_addr, o_psram_din,
        output i_psram_busy, i_psram_done, i_psram_dout
    );
endinterface

// File: rtl/psram_bist_pattern.sv
// Expected-data generator: address XOR mask, or a seeded LFSR when PSRAM_BIST_LFSR_EN is defined.
module psram_bist_pattern
    import psram_bist_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_PATTERN_XOR
)(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic        i_adv,
    input  logic [15:0] i_addr,
    output logic [15:0] o_exp
);
`ifdef PSRAM_BIST_LFSR_EN
    logic [15:0] r_lfsr;
    logic        w_fb;
    logic [15:0] w_unused_addr;

    assign w_fb          = ^(r_lfsr & LFSR_TAPS);
    assign w_unused_addr = i_addr;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)       r_lfsr <= SEED;
        else if (i_load) r_lfsr <= SEED;
        else if (i_adv)  r_lfsr <= {r_lfsr[14:0], w_fb};
    end

    // Seed is visible in the load cycle so the first word's data can be registered alongside it
    assign o_exp = i_load ? SEED : r_lfsr;
`else
    logic w_unused;

    assign w_unused = ^{i_clk, i_rst, i_load, i_adv};
    assign o_exp    = i_addr ^ SEED;
`endif
endmodule

// File: rtl/psram_bist.sv
// PSRAM write/read-back self-test sequencer. Optional LFSR pattern: define PSRAM_BIST_LFSR_EN.
module psram_bist
    import psram_bist_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 24,
    parameter logic [ADDR_W-1:0] ADDR_FIRST  = 24'h000000,
    parameter logic [ADDR_W-1:0] ADDR_LAST   = 24'h0000FE,
    parameter int unsigned       ADDR_STEP   = 2,
    parameter logic [15:0]       PATTERN_XOR = DEFAULT_PATTERN_XOR,
    parameter int unsigned       TIMEOUT     = 1023
)(
    input  logic              i_clk,
    input  logic              arst,
    input  logic              i_start,
    output logic              o_running,
    output logic              o_pass,
    output logic              o_fail,
    output logic              o_timeout,
    output logic [15:0]       o_err_cnt,
    output logic [ADDR_W-1:0] o_first_err_addr,
    output logic [15:0]       o_first_err_got,
    psram_bist_if.master      psram
);
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    state_t            r_state, w_state_nxt;
    logic [TMR_W-1:0]  r_timer;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [ADDR_W-1:0] r_bus_addr, r_first_addr;
    logic [15:0]       r_bus_din, r_rdata, r_err_cnt, r_first_got, w_exp;
    logic              r_bus_we, r_running, r_pass, r_fail, r_tmo;
    logic              w_ready, w_in_wait, w_stb, w_tmo, w_adv, w_seed, w_start, w_load_bus;

    assign w_ready   = psram.i_psram_done && !psram.i_psram_busy;
    assign w_in_wait = (r_state == WR_ACK) || (r_state == WR_WAIT) ||
                       (r_state == RD_ACK) || (r_state == RD_WAIT);

    psram_bist_pattern #(.SEED(PATTERN_XOR)) u_pattern (
        .i_clk  (i_clk),
        .i_rst  (arst),
        .i_load (w_seed),
        .i_adv  (w_adv),
        .i_addr (w_addr_nxt[15:0]),
        .o_exp  (w_exp)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr + ADDR_W'(ADDR_STEP);
        w_stb       = 1'b0;
        w_tmo       = 1'b0;
        w_adv       = 1'b0;
        w_seed      = 1'b0;
        w_start     = 1'b0;
        case (r_state)
            IDLE: if (i_start) begin
                w_start     = 1'b1;
                w_seed      = 1'b1;
                w_addr_nxt  = ADDR_FIRST;
                w_state_nxt = WR_REQ;
            end
            WR_REQ: if (w_ready) begin
                w_stb       = 1'b1;
                w_state_nxt = WR_ACK;
            end
            WR_ACK: if (psram.i_psram_busy) begin
                w_adv       = 1'b1;
                w_state_nxt = WR_WAIT;
            end
            WR_WAIT: if (w_ready) begin
                if (r_addr == ADDR_LAST) begin
                    w_seed      = 1'b1;
                    w_addr_nxt  = ADDR_FIRST;
                    w_state_nxt = RD_REQ;
                end else begin
                    w_state_nxt = WR_REQ;
                end
            end
            RD_REQ: if (w_ready) begin
                w_stb       = 1'b1;
                w_state_nxt = RD_ACK;
            end
            RD_ACK: if (psram.i_psram_busy) begin
                w_adv       = 1'b1;
                w_state_nxt = RD_WAIT;
            end
            RD_WAIT: if (w_ready) w_state_nxt = CHECK;
            CHECK:   w_state_nxt = (r_addr == ADDR_LAST) ? DONE : RD_REQ;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (w_in_wait && (w_state_nxt == r_state) && (r_timer == TMR_W'(TIMEOUT))) begin
            w_tmo       = 1'b1;
            w_state_nxt = IDLE;
        end
    end

    // Bus registers load only on entry to a request state, so they hold until the next one
    assign w_load_bus = ((w_state_nxt == WR_REQ) || (w_state_nxt == RD_REQ)) &&
                        (w_state_nxt != r_state);

    always_ff @(posedge i_clk or posedge arst) begin
        if (arst) begin
            r_state      <= IDLE;
            r_timer      <= '0;
            r_addr       <= ADDR_FIRST;
            r_bus_addr   <= '0;
            r_bus_din    <= '0;
            r_bus_we     <= 1'b0;
            r_rdata      <= '0;
            r_err_cnt    <= '0;
            r_first_addr <= '0;
            r_first_got  <= '0;
            r_running    <= 1'b0;
            r_pass       <= 1'b0;
            r_fail       <= 1'b0;
            r_tmo        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state) r_timer <= '0;
            else if (w_in_wait)         r_timer <= r_timer + 1'b1;

            if (w_start) begin
                r_running    <= 1'b1;
                r_pass       <= 1'b0;
                r_fail       <= 1'b0;
                r_tmo        <= 1'b0;
                r_err_cnt    <= '0;
                r_first_addr <= '0;
                r_first_got  <= '0;
            end
            if (w_load_bus) begin
                r_addr     <= w_addr_nxt;
                r_bus_addr <= w_addr_nxt;
                r_bus_din  <= w_exp;
                r_bus_we   <= (w_state_nxt == WR_REQ);
            end
            if ((r_state == RD_WAIT) && w_ready) r_rdata <= psram.i_psram_dout;
            // During reads r_bus_din holds the expected word for the current address
            if ((r_state == CHECK) && (r_rdata != r_bus_din)) begin
                if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 16'd1;
                if (r_err_cnt == '0) begin
                    r_first_addr <= r_addr;
                    r_first_got  <= r_rdata;
                end
            end
            if (r_state == DONE) begin
                r_running <= 1'b0;
                r_pass    <= (r_err_cnt == '0);
                r_fail    <= (r_err_cnt != '0);
            end
            if (w_tmo) begin
                r_running <= 1'b0;
                r_tmo     <= 1'b1;
                r_fail    <= 1'b1;
            end
        end
    end

    assign psram.o_psram_stb  = w_stb;
    assign psram.o_psram_we   = r_bus_we;
    assign psram.o_psram_addr = r_bus_addr;
    assign psram.o_psram_din  = r_bus_din;
    assign o_running          = r_running;
    assign o_pass             = r_pass;
    assign o_fail             = r_fail;
    assign o_timeout          = r_tmo;
    assign o_err_cnt          = r_err_cnt;
    assign o_first_err_addr   = r_first_addr;
    assign o_first_err_got    = r_first_got;
endmodule

// File: tb/tb_psram_bist.sv
// Self-checking bench for psram_bist with a behavioural PSRAM controller and memory model.
module tb_psram_bist;
    localparam int N_WORDS = 128;

    logic        i_clk = 1'b0;
    logic        arst, i_start;
    logic        o_running, o_pass, o_fail, o_timeout;
    logic [15:0] o_err_cnt, o_first_err_got;
    logic [23:0] o_first_err_addr;

    int n_pass = 0;
    int n_chk  = 0;

    psram_bist_if #(.ADDR_W(24)) bus ();

    psram_bist #(
        .ADDR_W      (24),
        .ADDR_FIRST  (24'h000000),
        .ADDR_LAST   (24'h0000FE),
        .ADDR_STEP   (2),
        .PATTERN_XOR (16'hA55A),
        .TIMEOUT     (1023)
    ) dut (
        .i_clk            (i_clk),
        .arst             (arst),
        .i_start          (i_start),
        .o_running        (o_running),
        .o_pass           (o_pass),
        .o_fail           (o_fail),
        .o_timeout        (o_timeout),
        .o_err_cnt        (o_err_cnt),
        .o_first_err_addr (o_first_err_addr),
        .o_first_err_got  (o_first_err_got),
        .psram            (bus)
    );

    always #5 i_clk = ~i_clk;

    // Expected data for a word address, straight from the pattern rule
    function automatic logic [15:0] exp_pat(input logic [23:0] a);
`ifdef PSRAM_BIST_LFSR_EN
        logic [15:0] v;
        v = 16'hA55A;
        for (int k = 0; k < int'(a) / 2; k++) v = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
        return v;
`else
        return a[15:0] ^ 16'hA55A;
`endif
    endfunction

    // Controller model: accept one negedge after the strobe, busy for lat cycles, then done
    bit          hang;
    int          lat_min, lat_max, cnt;
    bit          pend, act;
    logic [15:0] mem   [N_WORDS];
    logic [15:0] cmask [N_WORDS];
    logic [23:0] c_addr;
    logic [15:0] c_din;
    logic        c_we, prev_stb;
    int          n_wr, n_rd, n_stb, viol, bad_wr;

    always @(negedge i_clk) begin
        if (arst) begin
            pend = 0; act = 0; prev_stb = 0;
            bus.i_psram_busy = 0; bus.i_psram_done = 1;
        end else begin
            if (bus.o_psram_stb && prev_stb) viol++;
            if (bus.o_psram_stb && !(bus.i_psram_done && !bus.i_psram_busy)) viol++;
            if ((pend || act) && (bus.o_psram_addr !== c_addr || bus.o_psram_din !== c_din ||
                                  bus.o_psram_we !== c_we)) viol++;
            if (act) begin
                if (cnt > 1) cnt--;
                else begin
                    act = 0; bus.i_psram_busy = 0; bus.i_psram_done = 1;
                    if (c_addr > 24'hFE || c_addr[0]) viol++;
                    else if (c_we) begin
                        mem[c_addr >> 1] = c_din; n_wr++;
                        if (c_din !== exp_pat(c_addr)) bad_wr++;
                    end else begin
                        bus.i_psram_dout = mem[c_addr >> 1] ^ cmask[c_addr >> 1]; n_rd++;
                    end
                end
            end else if (pend) begin
                pend = 0; act = 1; bus.i_psram_busy = 1; bus.i_psram_done = 0;
                cnt = $urandom_range(lat_max, lat_min);
            end else if (bus.o_psram_stb) begin
                n_stb++;
                if (!hang) begin
                    pend = 1; c_addr = bus.o_psram_addr; c_din = bus.o_psram_din; c_we = bus.o_psram_we;
                end
            end
            prev_stb = bus.o_psram_stb;
        end
    end

    task automatic clear_model(input int lmin, input int lmax);
        hang = 0; lat_min = lmin; lat_max = lmax;
        n_wr = 0; n_rd = 0; n_stb = 0; viol = 0; bad_wr = 0;
        for (int i = 0; i < N_WORDS; i++) cmask[i] = '0;
    endtask

    task automatic start_pulse();
        @(negedge i_clk) i_start = 1;
        @(negedge i_clk) i_start = 0;
    endtask

    task automatic wait_finish(input int budget, output bit fin, output int cyc, output int drops);
        fin = 0; cyc = 0; drops = 0;
        while (!fin && cyc < budget) begin
            @(negedge i_clk);
            cyc++;
            if (o_pass || o_fail) fin = 1;
            else if (!o_running) drops++;
        end
    endtask

    task automatic wait_count(input int which_rd, input int target, output bit ok);
        ok = 0;
        for (int c = 0; c < 5000 && !ok; c++) begin
            @(negedge i_clk);
            ok = ((which_rd != 0) ? n_rd : n_wr) >= target;
        end
    endtask

    task automatic test_reset();
        arst = 1; i_start = 0;
        repeat (3) @(negedge i_clk);
        n_chk++; if ({o_running, o_pass, o_fail, o_timeout} !== 4'b0) $display("FAIL reset_flags got=%b want=0000", {o_running, o_pass, o_fail, o_timeout}); else n_pass++;
        n_chk++; if ({o_err_cnt, o_first_err_addr, o_first_err_got} !== '0) $display("FAIL reset_err got=%h/%h/%h want=0", o_err_cnt, o_first_err_addr, o_first_err_got); else n_pass++;
        n_chk++; if ({bus.o_psram_stb, bus.o_psram_we, bus.o_psram_addr, bus.o_psram_din} !== '0) $display("FAIL reset_bus got stb=%b we=%b addr=%h din=%h want=0", bus.o_psram_stb, bus.o_psram_we, bus.o_psram_addr, bus.o_psram_din); else n_pass++;
        arst = 0;
    endtask

    task automatic test_clean_pass();
        bit fin; int cyc, drops;
        clear_model(5, 5);
        start_pulse();
        wait_finish(20000, fin, cyc, drops);
        n_chk++; if (!fin) $display("FAIL clean_finish got=timeout_after_%0d want=finished", cyc); else n_pass++;
        n_chk++; if ({o_pass, o_fail, o_timeout} !== 3'b100) $display("FAIL clean_flags got=%b want=100", {o_pass, o_fail, o_timeout}); else n_pass++;
        n_chk++; if (o_err_cnt !== 16'd0) $display("FAIL clean_errcnt got=%0d want=0", o_err_cnt); else n_pass++;
        n_chk++; if (n_wr !== N_WORDS || n_rd !== N_WORDS) $display("FAIL clean_xfers got=%0d/%0d want=%0d/%0d", n_wr, n_rd, N_WORDS, N_WORDS); else n_pass++;
        n_chk++; if (drops !== 0) $display("FAIL clean_running got=%0d_low_cycles want=0", drops); else n_pass++;
        n_chk++; if (viol !== 0 || bad_wr !== 0) $display("FAIL clean_protocol got=viol%0d/badwr%0d want=0/0", viol, bad_wr); else n_pass++;
    endtask

    task automatic run_errors(input string name);
        bit fin; int cyc, drops, exp_cnt;
        logic [23:0] exp_addr;
        logic [15:0] exp_got;
        exp_cnt = 0; exp_addr = '0; exp_got = '0;
        for (int i = N_WORDS - 1; i >= 0; i--) if (cmask[i] != 0) begin
            exp_cnt++; exp_addr = 24'(i * 2); exp_got = exp_pat(exp_addr) ^ cmask[i];
        end
        start_pulse();
        wait_finish(20000, fin, cyc, drops);
        n_chk++; if (!fin) $display("FAIL %s_finish got=timeout_after_%0d want=finished", name, cyc); else n_pass++;
        n_chk++; if ({o_pass, o_fail, o_timeout} !== 3'b010) $display("FAIL %s_flags got=%b want=010", name, {o_pass, o_fail, o_timeout}); else n_pass++;
        n_chk++; if (o_err_cnt !== 16'(exp_cnt)) $display("FAIL %s_errcnt got=%0d want=%0d", name, o_err_cnt, exp_cnt); else n_pass++;
        n_chk++; if (o_first_err_addr !== exp_addr || o_first_err_got !== exp_got) $display("FAIL %s_first got=%h:%h want=%h:%h", name, o_first_err_addr, o_first_err_got, exp_addr, exp_got); else n_pass++;
        n_chk++; if (viol !== 0 || bad_wr !== 0) $display("FAIL %s_protocol got=viol%0d/badwr%0d want=0/0", name, viol, bad_wr); else n_pass++;
    endtask

    task automatic test_single_error();
        clear_model(1, 6);
        cmask[8'h10 >> 1] = 16'h0008;
        run_errors("single_err");
    endtask

    task automatic test_two_errors();
        clear_model(1, 6);
        cmask[8'h20 >> 1] = 16'h1 << $urandom_range(15, 0);
        cmask[8'h40 >> 1] = 16'h1 << $urandom_range(15, 0);
        run_errors("two_err");
    endtask

    task automatic test_random_errors();
        int k;
        clear_model(1, 4);
        k = $urandom_range(6, 1);
        for (int i = 0; i < k; i++) cmask[$urandom_range(N_WORDS - 1, 0)] = 16'($urandom_range(16'hFFFF, 1));
        run_errors("rand_err");
    endtask

    task automatic test_timeout();
        bit fin; int cyc, drops;
        clear_model(5, 5);
        hang = 1;
        start_pulse();
        wait_finish(3000, fin, cyc, drops);
        n_chk++; if (!fin) $display("FAIL tmo_finish got=no_end_after_%0d want=finished", cyc); else n_pass++;
        n_chk++; if ({o_timeout, o_fail, o_pass, o_running} !== 4'b1100) $display("FAIL tmo_flags got=%b want=1100", {o_timeout, o_fail, o_pass, o_running}); else n_pass++;
        n_chk++; if (cyc < 1023) $display("FAIL tmo_latency got=%0d want>=1023", cyc); else n_pass++;
        n_chk++; if (bus.o_psram_stb !== 1'b0 || n_stb !== 1) $display("FAIL tmo_stb got=stb%b/n%0d want=0/1", bus.o_psram_stb, n_stb); else n_pass++;
        hang = 0;
    endtask

    task automatic test_reset_mid_read();
        bit ok, fin; int cyc, drops;
        clear_model(1, 6);
        start_pulse();
        wait_count(1, 10, ok);
        n_chk++; if (!ok) $display("FAIL midrst_reach got=%0d_reads want>=10", n_rd); else n_pass++;
        @(negedge i_clk);
        #2 arst = 1;
        #1;
        n_chk++; if (bus.o_psram_stb !== 1'b0 || o_running !== 1'b0) $display("FAIL midrst_async got=stb%b/run%b want=0/0", bus.o_psram_stb, o_running); else n_pass++;
        repeat (2) @(negedge i_clk);
        n_chk++; if ({o_pass, o_fail, o_timeout, o_err_cnt, o_first_err_addr, bus.o_psram_addr, bus.o_psram_din} !== '0) $display("FAIL midrst_zero got=%b%b%b/%h/%h/%h/%h want=0", o_pass, o_fail, o_timeout, o_err_cnt, o_first_err_addr, bus.o_psram_addr, bus.o_psram_din); else n_pass++;
        arst = 0;
        clear_model(1, 6);
        start_pulse();
        wait_finish(20000, fin, cyc, drops);
        n_chk++; if (!fin || {o_pass, o_fail} !== 2'b10) $display("FAIL midrst_rerun got=fin%b/pf%b%b want=1/10", fin, o_pass, o_fail); else n_pass++;
        n_chk++; if (n_wr !== N_WORDS || n_rd !== N_WORDS || viol !== 0) $display("FAIL midrst_xfers got=%0d/%0d/v%0d want=%0d/%0d/v0", n_wr, n_rd, viol, N_WORDS, N_WORDS); else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit ok, fin; int cyc, drops;
        clear_model(1, 3);
        start_pulse();
        wait_count(0, 20, ok);
        start_pulse();
        wait_finish(20000, fin, cyc, drops);
        n_chk++; if (!ok || !fin || {o_pass, o_fail} !== 2'b10) $display("FAIL b2b_first got=ok%b/fin%b/pf%b%b want=1/1/10", ok, fin, o_pass, o_fail); else n_pass++;
        n_chk++; if (n_wr !== N_WORDS || n_rd !== N_WORDS) $display("FAIL b2b_ignore_start got=%0d/%0d want=%0d/%0d", n_wr, n_rd, N_WORDS, N_WORDS); else n_pass++;
        start_pulse();
        wait_finish(20000, fin, cyc, drops);
        n_chk++; if (!fin || {o_pass, o_fail} !== 2'b10 || drops !== 0) $display("FAIL b2b_second got=fin%b/pf%b%b/d%0d want=1/10/0", fin, o_pass, o_fail, drops); else n_pass++;
        n_chk++; if (n_wr !== 2 * N_WORDS || n_rd !== 2 * N_WORDS || viol !== 0 || bad_wr !== 0) $display("FAIL b2b_xfers got=%0d/%0d/v%0d/b%0d want=%0d/%0d/v0/b0", n_wr, n_rd, viol, bad_wr, 2 * N_WORDS, 2 * N_WORDS); else n_pass++;
    endtask

    initial begin
        bus.i_psram_busy = 0; bus.i_psram_done = 1; bus.i_psram_dout = '0;
        clear_model(5, 5);
        test_reset();
        test_clean_pass();
        test_single_error();
        test_two_errors();
        test_random_errors();
        test_timeout();
        test_reset_mid_read();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/psram_bist.md
Name: psram_bist

Overview:
- Built-in self-test sequencer that sits directly upstream of the PSRAM controller. It drives the controller's strobe, write-enable, address and write-data inputs, and consumes its busy, done and read-data outputs.
- Writes a deterministic 16-bit pattern over a configurable address window, then reads the window back and compares.
- Reports pass/fail, error count and first failing address/data to the board top (LEDs/UART).

Parameters:
- ADDR_W, 24: controller address width.
- ADDR_FIRST, 24'h000000: first word address tested (must be a multiple of ADDR_STEP).
- ADDR_LAST, 24'h0000FE: last word address tested, inclusive (ADDR_LAST - ADDR_FIRST must be a multiple of ADDR_STEP).
- ADDR_STEP, 2: address increment per 16-bit transaction (bytes).
- PATTERN_XOR, 16'hA55A: XOR mask applied to the address-derived pattern.
- TIMEOUT, 1023: maximum cycles waiting for any controller response before a timeout fail.

Ports:
- i_clk, in, 1: system clock; the same clock as the controller.
- arst, in, 1: asynchronous, active-high reset.
- i_start, in, 1: single-cycle start request.
- o_running, out, 1: test in progress.
- o_pass, out, 1: test finished with zero errors. Sticky until next start or reset.
- o_fail, out, 1: test finished with errors or a timeout. Sticky.
- o_timeout, out, 1: fail caused by a controller timeout. Sticky.
- o_err_cnt, out, 16: mismatch count, saturating at 16'hFFFF.
- o_first_err_addr, out, ADDR_W: address of the first mismatch.
- o_first_err_got, out, 16: data read at the first mismatch.
- o_psram_stb, out, 1: request strobe to the controller.
- o_psram_we, out, 1: 1 = write, 0 = read.
- o_psram_addr, out, ADDR_W: transaction address.
- o_psram_din, out, 16: write data.
- i_psram_busy, in, 1: controller busy.
- i_psram_done, in, 1: controller done / idle.
- i_psram_dout, in, 16: controller read data.

Behaviour:
- Reset values: all outputs 0; state IDLE; internal address = ADDR_FIRST; timer = 0.
- Controller ready condition: i_psram_done=1 and i_psram_busy=0.
- o_psram_addr, o_psram_we and o_psram_din are registered. They are held stable from the strobe cycle until done returns, because the controller samples the address across several cycles.
- Pattern for address A: exp(A) = A[15:0] ^ PATTERN_XOR.
- States:
  - IDLE: on i_start, clear the sticky flags, o_err_cnt and the first-error registers; addr = ADDR_FIRST; set o_running=1; go to WR_REQ. A start while running is ignored.
  - WR_REQ: wait for ready. When ready, drive o_psram_stb=1 for exactly one cycle, with we=1 and din=exp(addr). Go to WR_ACK.
  - WR_ACK: wait for i_psram_busy=1 (the controller accepted). Go to WR_WAIT.
  - WR_WAIT: wait for ready. If addr==ADDR_LAST, set addr=ADDR_FIRST and go to RD_REQ. Otherwise addr += ADDR_STEP and go to WR_REQ.
  - RD_REQ / RD_ACK / RD_WAIT: same handshake as the write states, with we=0.
  - RD_WAIT: when ready, capture i_psram_dout the same cycle and go to CHECK.
  - CHECK (1 cycle): on mismatch, increment o_err_cnt (saturating). If it was 0 before, also capture o_first_err_addr and o_first_err_got. Then, if addr==ADDR_LAST, go to DONE; otherwise addr += ADDR_STEP and go to RD_REQ.
  - DONE (1 cycle): o_running=0. o_pass = (err_cnt==0); o_fail = !o_pass. Go to IDLE.
- Timeout: the timer counts in every ACK and WAIT state and clears on each state change. If it reaches TIMEOUT: set o_timeout=1 and o_fail=1, clear o_running, force o_psram_stb=0, go to IDLE.
- Strobe rule: never asserted outside REQ states, never asserted for two consecutive cycles.
- Window boundaries: ADDR_FIRST==ADDR_LAST gives exactly one write and one read. Address never exceeds ADDR_LAST; no wrap.
- Reset mid-test:
  - Everything returns to reset values immediately and o_psram_stb drops asynchronously.
  - The top ties the controller's reset to the same source, so no half transaction survives.

Optional Feature:
- PSRAM_BIST_LFSR_EN defined:
  - Pattern comes from a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1), seeded with PATTERN_XOR (which must be nonzero) at the start of each pass.
  - It advances once per accepted write and once per accepted read, so the read pass reproduces the write sequence.
- Undefined: address-XOR pattern as above; no LFSR logic.

Decomposition:
- Shared package psram_bist_pkg:
  - state enum (IDLE, WR_REQ, WR_ACK, WR_WAIT, RD_REQ, RD_ACK, RD_WAIT, CHECK, DONE);
  - LFSR tap constant;
  - default PATTERN_XOR.
- One sub-module, psram_bist_pattern: generates exp() from the address or the LFSR, with load/advance inputs. Compiled under the macro.

Test Plan:
- Start with a behavioural controller model (5-cycle busy, perfect memory) and window 0x0..0xFE → 128 writes then 128 reads; o_pass=1, o_err_cnt=0; o_running high throughout.
- Model corrupts the read at 0x10 (bit 3 flipped) → o_fail=1, o_err_cnt=1, o_first_err_addr=0x10, o_first_err_got=0x10^0xA55A^0x0008.
- Model corrupts 0x20 and 0x40 → o_err_cnt=2; first-error registers still report 0x20.
- Model never raises busy after the first strobe → after 1023 cycles o_timeout=1, o_fail=1, o_psram_stb=0.
- Assert arst during the read pass, then release and pulse i_start → all outputs 0 after reset; a clean rerun ends with o_pass=1.
- Check on every transaction that o_psram_stb is a 1-cycle pulse and that o_psram_addr/o_psram_din stay unchanged until done.
